// File: rtl/pixel_frequency_monitor_pkg.sv
// Shared types and constants for the pixel frequency monitor: FSM encoding,
// register map layout and the register-write payload.
package pixel_frequency_monitor_pkg;

  localparam int unsigned IDX_W      = 11;
  localparam int unsigned REG_NUM_W  = 8;
  localparam int unsigned REG_DATA_W = 32;

  // Per-channel register offsets within a channel's pair of registers
  localparam int unsigned EDGE_OFS   = 0;
  localparam int unsigned PERIOD_OFS = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DUMP    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [REG_NUM_W-1:0]  number;
    logic [REG_DATA_W-1:0] data;
  } reg_write_t;

  // Status register follows the 2*channels per-channel registers (1-based)
  function automatic int unsigned status_reg_num(input int unsigned channels);
    return 2 * channels + 1;
  endfunction

endpackage

// File: rtl/pixel_frequency_monitor_if.sv
// Register-write handshake towards the AXI slave register file.
interface pixel_frequency_monitor_if
  import pixel_frequency_monitor_pkg::*;
;
  logic                  reg_valid;
  logic                  reg_ready;
  logic [REG_NUM_W-1:0]  reg_number;
  logic [REG_DATA_W-1:0] reg_data;

  modport master (output reg_valid, output reg_number, output reg_data, input  reg_ready);
  modport slave  (input  reg_valid, input  reg_number, input  reg_data, output reg_ready);
endinterface

// File: rtl/pixel_frequency_monitor_channel.sv
// One monitored pixel: hysteresis binariser plus saturating rising-edge
// count, last edge-to-edge period and overflow flag.
module pixel_channel_meter
  import pixel_frequency_monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned THRESHOLD_HIGH = 100,
  parameter int unsigned THRESHOLD_LOW  = 80,
  parameter int unsigned COUNTER_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sample,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic [COUNTER_WIDTH-1:0] edge_count,
  output logic [COUNTER_WIDTH-1:0] last_period,
  output logic                     ovf
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic                     bin;
  logic                     bin_next_c;
  logic                     rise_c;
  logic [COUNTER_WIDTH-1:0] cycle_count;

  // Between the thresholds the previous binarised value is held
  always_comb begin
    bin_next_c = bin;
    if (sample) begin
      if (32'(data) > THRESHOLD_HIGH)     bin_next_c = 1'b1;
      else if (32'(data) < THRESHOLD_LOW) bin_next_c = 1'b0;
    end
  end

  assign rise_c = en && bin_next_c && !bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin         <= 1'b0;
      cycle_count <= '0;
      edge_count  <= '0;
      last_period <= '0;
      ovf         <= 1'b0;
    end else if (clr) begin
      bin         <= 1'b0;
      cycle_count <= '0;
      edge_count  <= '0;
      last_period <= '0;
      ovf         <= 1'b0;
    end else if (en) begin
      bin <= bin_next_c;
      if (rise_c) begin
        cycle_count <= '0;
        if (edge_count == CNT_MAX) ovf <= 1'b1;
        else                       edge_count <= edge_count + COUNTER_WIDTH'(1);
        // A period needs a previous edge to measure from
        if (edge_count != '0) begin
          if (cycle_count == CNT_MAX) begin
            last_period <= CNT_MAX;
            ovf         <= 1'b1;
          end else begin
            last_period <= cycle_count + COUNTER_WIDTH'(1);
          end
        end
      end else if (cycle_count != CNT_MAX) begin
        cycle_count <= cycle_count + COUNTER_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_frequency_monitor.sv
// Monitors CHANNELS pixel positions of a line-scan stream and dumps edge
// counts, periods and overflow status through a register-write handshake.
module pixel_frequency_monitor
  import pixel_frequency_monitor_pkg::*;
#(
  parameter int unsigned                 CHANNELS          = 4,
  parameter int unsigned                 DATA_WIDTH        = 8,
  parameter int unsigned                 LINE_LENGTH       = 1024,
  parameter int unsigned                 DARK_PIXELS_COUNT = 16,
  parameter logic [CHANNELS*IDX_W-1:0]   PIXEL_INDICES     = {11'd1023, 11'd511, 11'd255, 11'd63},
  parameter int unsigned                 THRESHOLD_HIGH    = 100,
  parameter int unsigned                 THRESHOLD_LOW     = 80,
  parameter int unsigned                 COUNTER_WIDTH     = 32
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  pixel_valid,
  input  logic                  line_start,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  pixel_frequency_monitor_if.master reg_if,
  output logic                  irq,
  output logic                  busy
);

  localparam int unsigned LINE_TOTAL = LINE_LENGTH + DARK_PIXELS_COUNT;
  localparam int unsigned PIX_W      = (LINE_TOTAL > 1) ? $clog2(LINE_TOTAL) : 1;
  localparam int unsigned LAST_REG   = status_reg_num(CHANNELS);

  state_e     state_q, state_d;
  reg_write_t wr_q, wr_d;
  logic       valid_q, valid_d;
  logic       irq_q, irq_d;
  logic       busy_q, busy_d;

  logic [PIX_W-1:0] pix_cnt;
  logic [PIX_W-1:0] cur_pix_c;
  logic [PIX_W-1:0] pix_next_c;
  logic             cap_en_c;
  logic             clr_stats_c;

  logic [COUNTER_WIDTH-1:0] edge_arr   [CHANNELS];
  logic [COUNTER_WIDTH-1:0] period_arr [CHANNELS];
  logic [CHANNELS-1:0]      ovf_vec;
  logic [REG_NUM_W-1:0]     rd_sel_c;
  logic [REG_DATA_W-1:0]    rd_data_c;

  // Counters run only in a capture cycle that is not being ended or aborted
  assign cap_en_c    = (state_q == ST_CAPTURE) && !stop && !clear;
  assign clr_stats_c = (state_q == ST_IDLE) && start && !clear;

  // line_start resyncs the current pixel to position 0
  assign cur_pix_c  = line_start ? '0 : pix_cnt;
  assign pix_next_c = (32'(cur_pix_c) == LINE_TOTAL - 1) ? '0 : cur_pix_c + PIX_W'(1);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)            pix_cnt <= '0;
    else if (clr_stats_c)            pix_cnt <= '0;
    else if (cap_en_c && pixel_valid) pix_cnt <= pix_next_c;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam int unsigned TAP = DARK_PIXELS_COUNT + 32'(PIXEL_INDICES[g*IDX_W +: IDX_W]);
    logic sample_c;
    assign sample_c = pixel_valid && (32'(cur_pix_c) == TAP);

    pixel_channel_meter #(
      .DATA_WIDTH     (DATA_WIDTH),
      .THRESHOLD_HIGH (THRESHOLD_HIGH),
      .THRESHOLD_LOW  (THRESHOLD_LOW),
      .COUNTER_WIDTH  (COUNTER_WIDTH)
    ) u_meter (
      .clk         (s00_axi_aclk),
      .rst_n       (s00_axi_aresetn),
      .clr         (clr_stats_c),
      .en          (cap_en_c),
      .sample      (sample_c),
      .data        (pixel_data),
      .edge_count  (edge_arr[g]),
      .last_period (period_arr[g]),
      .ovf         (ovf_vec[g])
    );
  end

  // Register value for the write about to be presented
  assign rd_sel_c = (state_q == ST_CAPTURE) ? REG_NUM_W'(1) : wr_q.number + REG_NUM_W'(1);

  always_comb begin
    rd_data_c = {16'b0, 16'(ovf_vec)};
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_sel_c == REG_NUM_W'(2*c + 1 + EDGE_OFS))   rd_data_c = 32'(edge_arr[c]);
      if (rd_sel_c == REG_NUM_W'(2*c + 1 + PERIOD_OFS)) rd_data_c = 32'(period_arr[c]);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
    end
  end

  // Next state and next registered outputs; clear overrides everything
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    valid_d = valid_q;
    irq_d   = irq_q;
    if (clear) begin
      state_d = ST_IDLE;
      wr_d    = '0;
      valid_d = 1'b0;
      irq_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stop) begin
            state_d     = ST_DUMP;
            valid_d     = 1'b1;
            wr_d.number = REG_NUM_W'(1);
            wr_d.data   = rd_data_c;
          end
        end
        ST_DUMP: begin
          if (valid_q && reg_if.reg_ready) begin
            if (32'(wr_q.number) == LAST_REG) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              irq_d   = 1'b1;
            end else begin
              wr_d.number = rd_sel_c;
              wr_d.data   = rd_data_c;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_CAPTURE) || (state_d == ST_DUMP);
  end

  assign reg_if.reg_valid  = valid_q;
  assign reg_if.reg_number = wr_q.number;
  assign reg_if.reg_data   = wr_q.data;
  assign irq               = irq_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_pixel_frequency_monitor.sv
// Directed bench: 2 channels, 10-pixel lines (2 dark + 8 active), taps at
// active pixels 1 and 5; a second instance uses 4-bit counters.
module tb_pixel_frequency_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pixel_data;
  logic       pixel_valid, line_start, start, stop, clear;
  logic       irq_a, irq_b, busy_a, busy_b;
  logic       rdy;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  logic        o_valid;
  logic [7:0]  o_num;
  logic [31:0] o_data;
  logic [31:0] exp_vals [0:15];
  int          b1_seq [0:9] = '{50, 120, 90, 120, 90, 50, 120, 50, 90, 50};

  pixel_frequency_monitor_if if_a ();
  pixel_frequency_monitor_if if_b ();

  assign if_a.reg_ready = rdy && (sel == 0);
  assign if_b.reg_ready = rdy && (sel == 1);
  assign o_valid = (sel == 1) ? if_b.reg_valid  : if_a.reg_valid;
  assign o_num   = (sel == 1) ? if_b.reg_number : if_a.reg_number;
  assign o_data  = (sel == 1) ? if_b.reg_data   : if_a.reg_data;

  always #5 clk = ~clk;

  pixel_frequency_monitor #(
    .CHANNELS(2), .DATA_WIDTH(8), .LINE_LENGTH(8), .DARK_PIXELS_COUNT(2),
    .PIXEL_INDICES({11'd5, 11'd1}), .THRESHOLD_HIGH(100), .THRESHOLD_LOW(80),
    .COUNTER_WIDTH(32)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .line_start(line_start), .start(start),
    .stop(stop), .clear(clear), .reg_if(if_a), .irq(irq_a), .busy(busy_a)
  );

  pixel_frequency_monitor #(
    .CHANNELS(2), .DATA_WIDTH(8), .LINE_LENGTH(8), .DARK_PIXELS_COUNT(2),
    .PIXEL_INDICES({11'd5, 11'd1}), .THRESHOLD_HIGH(100), .THRESHOLD_LOW(80),
    .COUNTER_WIDTH(4)
  ) dut4 (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .line_start(line_start), .start(start),
    .stop(stop), .clear(clear), .reg_if(if_b), .irq(irq_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int v0, input int v1);
    for (int p = 0; p < 10; p++) begin
      pixel_valid = 1'b1;
      line_start  = (p == 0);
      pixel_data  = (p == 3) ? 8'(v0) : (p == 7) ? 8'(v1) : 8'd0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_stop();
    pixel_valid = 1'b0;
    line_start  = 1'b0;
    pixel_data  = 8'd0;
    stop        = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("first_write_latency", 32'(o_valid), 32'd1);
  endtask

  // Accept nregs writes, holding reg_ready low for stall cycles before each
  task automatic collect(input int nregs, input int stall);
    for (int k = 0; k < nregs; k++) begin
      int guard;
      guard = 0;
      while (!o_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("valid_%0d", k + 1), 32'(o_valid), 32'd1);
      check($sformatf("num_%0d", k + 1), 32'(o_num), 32'(k + 1));
      check($sformatf("data_%0d", k + 1), o_data, exp_vals[k]);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check($sformatf("hold_num_%0d_%0d", k + 1, s), 32'(o_num), 32'(k + 1));
        check($sformatf("hold_data_%0d_%0d", k + 1, s), o_data, exp_vals[k]);
      end
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pixel_data = 8'd0; pixel_valid = 1'b0; line_start = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; rdy = 1'b0; sel = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(if_a.reg_valid), 32'd0);
    check("rst_num",   32'(if_a.reg_number), 32'd0);
    check("rst_data",  if_a.reg_data, 32'd0);
    check("rst_irq",   32'(irq_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Square wave on ch0: 5 rising edges, 20-cycle period
    pulse_start();
    check("a_busy", 32'(busy_a), 32'd1);
    for (int l = 0; l < 10; l++) drive_line((l % 2 == 0) ? 200 : 0, 0);
    pulse_stop();
    exp_vals[0] = 32'd5; exp_vals[1] = 32'd20; exp_vals[2] = 32'd0;
    exp_vals[3] = 32'd0; exp_vals[4] = 32'd0;
    collect(5, 0);
    check("a_irq", 32'(irq_a), 32'd1);
    check("a_valid_done", 32'(o_valid), 32'd0);
    check("a_busy_done", 32'(busy_a), 32'd0);
    pulse_clear();
    check("a_irq_clear", 32'(irq_a), 32'd0);

    // Hysteresis on ch1 with a stalling register file
    pulse_start();
    for (int l = 0; l < 10; l++) drive_line(0, b1_seq[l]);
    pulse_stop();
    exp_vals[0] = 32'd0; exp_vals[1] = 32'd0; exp_vals[2] = 32'd2;
    exp_vals[3] = 32'd50; exp_vals[4] = 32'd0;
    collect(5, 3);
    check("b_irq", 32'(irq_a), 32'd1);
    pulse_clear();

    // 4-bit counters: 20 edges saturate and flag overflow
    sel = 1;
    pulse_start();
    for (int l = 0; l < 40; l++) drive_line((l % 2 == 0) ? 200 : 0, 0);
    pulse_stop();
    exp_vals[0] = 32'd15; exp_vals[1] = 32'd15; exp_vals[2] = 32'd0;
    exp_vals[3] = 32'd0; exp_vals[4] = 32'd1;
    collect(5, 0);
    check("c_irq", 32'(irq_b), 32'd1);
    pulse_clear();
    check("c_irq_clear", 32'(irq_b), 32'd0);
    sel = 0;

    // Abort during dump, then restart from cleared statistics
    pulse_start();
    for (int l = 0; l < 5; l++) drive_line((l % 2 == 0) ? 200 : 0, 0);
    pulse_stop();
    exp_vals[0] = 32'd3; exp_vals[1] = 32'd20;
    collect(2, 0);
    check("d_num3_pending", 32'(o_num), 32'd3);
    pulse_clear();
    check("d_valid_abort", 32'(o_valid), 32'd0);
    check("d_busy_abort", 32'(busy_a), 32'd0);
    check("d_irq_abort", 32'(irq_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("d_irq_quiet", 32'(irq_a), 32'd0);
    end
    pulse_start();
    for (int l = 0; l < 2; l++) drive_line(0, 0);
    pulse_stop();
    for (int i = 0; i < 5; i++) exp_vals[i] = 32'd0;
    collect(5, 0);
    check("d_irq", 32'(irq_a), 32'd1);
    pulse_clear();

    // Asynchronous reset in the middle of a capture
    pulse_start();
    for (int l = 0; l < 3; l++) drive_line(200, 0);
    check("e_busy_pre", 32'(busy_a), 32'd1);
    pixel_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("e_busy_rst",  32'(busy_a), 32'd0);
    check("e_valid_rst", 32'(if_a.reg_valid), 32'd0);
    check("e_num_rst",   32'(if_a.reg_number), 32'd0);
    check("e_irq_rst",   32'(irq_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pixel_valid = 1'b0;
    @(negedge clk);
    check("e_idle_after", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_frequency_monitor.md
Name: pixel_frequency_monitor

Overview:
N-channel, single-clock generalisation of the pixel frequency analyzer manager. It watches CHANNELS configurable pixel positions in a line-scan stream, binarises each with a hysteresis threshold, and measures rising-edge count and last edge-to-edge period in clock cycles. After stop it dumps results through a register-write handshake to the AXI slave register file and raises irq. Sits between the camera pixel path and axi_slave_impl.

Parameters:
CHANNELS, 4, number of monitored pixels (1..15)
DATA_WIDTH, 8, pixel data width
LINE_LENGTH, 1024, active pixels per line
DARK_PIXELS_COUNT, 16, dark pixels preceding active pixels
PIXEL_INDICES, {11'd1023,11'd511,11'd255,11'd63}, flattened CHANNELS*11-bit active-pixel indices; channel i at bits [11i+10:11i]
THRESHOLD_HIGH, 100, binarised value goes 1 when data > THRESHOLD_HIGH
THRESHOLD_LOW, 80, binarised value goes 0 when data < THRESHOLD_LOW; must be <= THRESHOLD_HIGH
COUNTER_WIDTH, 32, width of period/edge counters (<=32)

Ports:
s00_axi_aclk  in  1  sole clock
s00_axi_aresetn  in  1  asynchronous active-low reset
pixel_data  in  DATA_WIDTH  pixel value, qualified by pixel_valid
pixel_valid  in  1  one pixel per cycle when high
line_start  in  1  marks first (dark) pixel of a line; only meaningful with pixel_valid
start  in  1  level/pulse; begin capture
stop  in  1  level/pulse; end capture, begin dump
clear  in  1  abort or acknowledge; returns to IDLE
reg_valid  out  1  register write request
reg_ready  in  1  register file accepts write
reg_number  out  8  register index (1-based)
reg_data  out  32  register value
irq  out  1  high in DONE
busy  out  1  high in CAPTURE or DUMP

Behaviour:
- Reset: FSM=IDLE, reg_valid=0, reg_number=0, reg_data=0, irq=0, busy=0, all counters/status=0, pixel counter=0.
- FSM IDLE->CAPTURE on start (stats cleared that cycle); CAPTURE->DUMP on stop (stop wins over start); DUMP->DONE after last accepted write; DONE->IDLE on clear. clear in CAPTURE or DUMP aborts to IDLE next cycle: reg_valid drops, irq stays 0. clear has priority over all other inputs. start outside IDLE ignored; stop outside CAPTURE ignored.
- Pixel counter (CAPTURE only): advances on pixel_valid; wraps LINE_LENGTH+DARK_PIXELS_COUNT-1 -> 0; pixel_valid&line_start forces current pixel to index 0 (resync).
- Channel i samples when pixel_valid and counter == DARK_PIXELS_COUNT + index_i. Hysteresis: bin<=1 if data>HIGH, bin<=0 if data<LOW, else hold. bin=0 on entering CAPTURE.
- Per channel: cycle counter increments every CAPTURE clock, saturates at all-ones. On rising edge of bin: edge_count+1 (saturating, sets ovf_i); if edge_count was >=1 before, last_period <= cycle counter+1 (saturate; sets ovf_i on saturation); cycle counter <= 0. Counters frozen outside CAPTURE.
- DUMP order: reg_number 1..2*CHANNELS = ch0 edge_count, ch0 last_period, ch1 ..., then 2*CHANNELS+1 = status {16'b0, ovf[15:0] zero-extended}. Values zero-extended to 32 bits. reg_valid/reg_number/reg_data stable until reg_valid&reg_ready; next write presented next cycle (one write per cycle max). First write appears 1 cycle after stop sampled.
- irq rises the cycle after last acceptance; level until clear.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, CAPTURE, DUMP, DONE), register map offsets (EDGE_OFS=0, PERIOD_OFS=1, STATUS_REG), index width 11.
- One sub-module pixel_channel_meter: hysteresis binariser + edge/period counters + ovf; instantiated CHANNELS times via generate.

Test Plan:
- Params CHANNELS=2, LINE_LENGTH=8, DARK=2, indices {5,1}, continuous pixel_valid: reset asserted mid-capture -> all outputs 0 immediately, FSM IDLE.
- ch0 pixel toggles 200/0 every line (line=10 clk): after 5 rising edges stop -> writes 1:5, 2:20, 3:0, 4:0, 5:0; irq high after 5th accept; clear -> irq 0.
- ch1 data 90 between 120 and 50 lines -> no edge on 90 (hold); edges only 50->120: edge_count matches 120-transitions exactly.
- reg_ready held low 3 cycles per write -> reg_number/reg_data stable while waiting, no skipped/duplicated numbers.
- COUNTER_WIDTH=4, 20 rising edges -> edge_count 15, status bit0=1.
- clear during DUMP after reg 2 accepted -> reg_valid 0 next cycle, irq never asserted, new start restarts from cleared stats.
